// File: rtl/form_trans_pkt_n8.sv
// Packet serialiser: buffers wide frame words in a show-ahead FIFO and
// emits them MSB byte first, with hunting, truncation, abort and gap.
module form_trans_pkt_n8 #(
   parameter int IN_BYTES   = 4,
   parameter int FIFO_AW    = 6,
   parameter int MAX_WORDS  = 64,
   parameter int GAP_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [8*IN_BYTES-1:0] din,
   input  logic                  din_sof,
   input  logic                  din_eof,
   input  logic [2:0]            din_bcnt,
   input  logic                  din_en,
   output logic                  din_full,
   output logic [7:0]            dout_8bit,
   output logic                  dout_8bit_en,
   output logic                  dout_8bit_sof,
   output logic                  dout_8bit_eof,
   input  logic                  dout_rdy,
   output logic                  ovf,
   output logic                  err_trunc,
   output logic                  err_abort
);

   localparam int DW    = 8 * IN_BYTES;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [7:0]       MAXW    = 8'(MAX_WORDS);
   localparam logic [8:0]       GAPW    = 9'(GAP_CYCLES);
   localparam logic [3:0]       NBW     = 4'(IN_BYTES);
   localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW+1)'(1);

   typedef struct packed {
      logic          sof;
      logic          eof;
      logic [2:0]    bcnt;
      logic [DW-1:0] data;
   } word_t;

   typedef enum logic [1:0] {IDLE, HUNT, SEND, GAP} state_t;

   word_t            mem [DEPTH];
   word_t            head;
   word_t            wr_word;
   logic [FIFO_AW:0] wr_ptr, rd_ptr, level;
   logic             full, empty, wr, pop;

   state_t     state, state_n;
   logic [2:0] idx, idx_n;
   logic [7:0] wcnt, wcnt_n;
   logic [7:0] gcnt, gcnt_n;
   logic       trunc_n, abort_n;

   logic [3:0]    nb;
   logic [DW-1:0] shifted;
   logic          last_byte, first_word, at_max, end_frame;
   logic          abort, send_en;

   // full is judged before any same-cycle pop, so a write into a full FIFO drops
   assign level    = wr_ptr - rd_ptr;
   assign full     = level[FIFO_AW];
   assign empty    = (level == '0);
   assign wr       = din_en && !full;
   assign head     = mem[rd_ptr[FIFO_AW-1:0]];
   assign din_full = full;
   assign wr_word  = '{sof: din_sof, eof: din_eof, bcnt: din_bcnt, data: din};

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr[FIFO_AW-1:0]] <= wr_word;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         if (din_en && full) ovf <= 1'b1;
      end
   end

   always_comb begin
      nb = NBW;
      if (head.eof && head.bcnt != 3'd0 && {1'b0, head.bcnt} < NBW)
         nb = {1'b0, head.bcnt};
   end

   assign shifted    = head.data << {idx, 3'b000};
   assign last_byte  = ({1'b0, idx} == nb - 4'd1);
   assign first_word = (wcnt == 8'd1);
   assign at_max     = (wcnt == MAXW);
   assign end_frame  = head.eof || at_max;
   // a fresh sof at a word boundary means the current frame lost its eof
   assign abort      = (state == SEND) && !empty && (idx == 3'd0) &&
                       !first_word && head.sof;
   assign send_en    = (state == SEND) && !empty && !abort;

   assign dout_8bit_en  = send_en;
   assign dout_8bit     = send_en ? shifted[DW-1 -: 8] : 8'h00;
   assign dout_8bit_sof = send_en && first_word && (idx == 3'd0);
   assign dout_8bit_eof = send_en && last_byte && end_frame;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= 3'd0;
         wcnt      <= 8'd0;
         gcnt      <= 8'd0;
         err_trunc <= 1'b0;
         err_abort <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         wcnt      <= wcnt_n;
         gcnt      <= gcnt_n;
         err_trunc <= trunc_n;
         err_abort <= abort_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      wcnt_n  = wcnt;
      gcnt_n  = gcnt;
      pop     = 1'b0;
      trunc_n = 1'b0;
      abort_n = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) state_n = HUNT;
         end
         HUNT: begin
            if (!empty) begin
               if (head.sof) begin
                  state_n = SEND;
                  idx_n   = 3'd0;
                  wcnt_n  = 8'd1;
               end else begin
                  pop = 1'b1;
               end
            end
         end
         SEND: begin
            if (abort) begin
               abort_n = 1'b1;
               state_n = GAP;
               gcnt_n  = 8'd0;
            end else if (send_en && dout_rdy) begin
               if (last_byte) begin
                  pop   = 1'b1;
                  idx_n = 3'd0;
                  if (end_frame) begin
                     state_n = GAP;
                     gcnt_n  = 8'd0;
                     trunc_n = !head.eof;
                  end else begin
                     wcnt_n = wcnt + 8'd1;
                  end
               end else begin
                  idx_n = idx + 3'd1;
               end
            end
         end
         GAP: begin
            if ({1'b0, gcnt} + 9'd1 >= GAPW) state_n = IDLE;
            else gcnt_n = gcnt + 8'd1;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: doc/form_trans_pkt_n8.md
# form_trans_pkt_n8

Parametrised packet serialiser: buffers IN_BYTES-wide words tagged with start/end-of-frame flags, then emits them one byte per cycle, MSB byte first. Adds partial last word, downstream backpressure, a programmable inter-frame gap, max-length truncation and abort handling. Sits between the ARP/UDP frame builders (wide side) and the 8-bit MAC transmit path.

## Interface
- IN_BYTES, 4, bytes per input word (2..8)
- FIFO_AW, 6, log2 of input FIFO depth in words (depth 64)
- MAX_WORDS, 64, longest legal frame in words (1..255)
- GAP_CYCLES, 8, idle cycles forced after every frame or abort (0..255)
- clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- din  in  8*IN_BYTES  input word, byte [8*IN_BYTES-1 -: 8] sent first
- din_sof  in  1  word is first of a frame
- din_eof  in  1  word is last of a frame
- din_bcnt  in  3  valid bytes in an eof word; 0 = IN_BYTES; ignored when din_eof=0
- din_en  in  1  write strobe
- din_full  out  1  FIFO full; words written while high are dropped
- dout_8bit  out  8  output byte
- dout_8bit_en  out  1  byte valid
- dout_8bit_sof  out  1  first byte of frame (qualified by en)
- dout_8bit_eof  out  1  last byte of frame (qualified by en)
- dout_rdy  in  1  downstream accepts byte this cycle
- ovf  out  1  sticky: a word was dropped on full
- err_trunc  out  1  one-cycle pulse: frame cut at MAX_WORDS
- err_abort  out  1  one-cycle pulse: SOF met before EOF

## Operation
- Reset (rst_n=0 at an edge): FIFO emptied, FSM to IDLE, counters 0; all outputs 0 (din_full=0, ovf=0). Reset mid-frame discards the frame with no eof.
- FIFO: 2^FIFO_AW entries of {sof, eof, bcnt, din}, show-ahead. Write when din_en && !din_full. din_en && din_full: word dropped, ovf set until reset. Simultaneous read and write when full: write dropped (full evaluated before the read).
- FSM states: IDLE, HUNT, SEND, GAP.
  - IDLE: FIFO non-empty -> HUNT.
  - HUNT: head word with sof=0 is popped and discarded (one per cycle); sof=1 -> SEND, byte index 0, word count 1. Empty -> stay.
  - SEND: present byte[idx] of head word. Byte advances only on dout_8bit_en && dout_rdy; otherwise dout_8bit and flags held stable. After last byte of a word (idx = IN_BYTES-1, or idx = bcnt-1 on eof word) the word is popped.
  - Popped word with eof -> GAP. Next head word with sof=1 and no prior eof -> err_abort pulse, word not popped, -> GAP (aborted frame never shows eof). Next word would be word MAX_WORDS+1 -> not consumed; the last byte of word MAX_WORDS is flagged eof, err_trunc pulses, -> GAP then HUNT discards rest until a sof.
  - SEND with FIFO empty mid-frame: dout_8bit_en=0, wait (underrun is not an error).
  - GAP: count GAP_CYCLES cycles with dout_8bit_en=0, then -> IDLE. GAP_CYCLES=0 passes through GAP in one cycle.
- sof=1 and eof=1 in the same word: single-word frame, both flags on the respective bytes; with bcnt=1 the one byte carries sof and eof.
- Word counter 8 bits, saturating at MAX_WORDS; byte index 3 bits, wraps to 0 per word.

## Timing
- din_en at edge E0 into empty FIFO, FSM IDLE, dout_rdy=1: HUNT after E1, first byte (dout_8bit_en=1, sof=1) valid after E2.
- Full-rate throughput: one byte per cycle while dout_rdy=1 and FIFO non-empty; no bubble between words of a frame.
- Frame of N bytes with dout_rdy=1: first byte to next frame's first byte = N + GAP_CYCLES + 2 cycles minimum (GAP, IDLE, HUNT).
- dout_rdy low stalls with zero latency; outputs unchanged until accepted.
- err_trunc, err_abort asserted for exactly the cycle the FSM enters GAP.
- din_full asserted the cycle after the write that fills the FIFO; deasserted the cycle after a pop from full.

## Test plan
- Two-word frame: din=0x11223344 sof, then 0x55667788 eof bcnt=0, dout_rdy=1 -> bytes 11..88 on 8 consecutive cycles, sof on 0x11, eof on 0x88, then 8 idle cycles.
- Partial last word: eof word 0xAABBCCDD bcnt=2 -> last bytes AA, BB with eof on BB; CC, DD never appear.
- Backpressure: toggle dout_rdy 1,0,0,1 during frame -> each byte held stable while rdy=0, exact byte sequence unchanged, no duplication or loss.
- Garbage then abort: sof=0 word 0xDEADBEEF, then sof frame 0x01020304, then sof 0x0A0B0C0D eof -> DEADBEEF discarded; 01..04 sent without eof; err_abort pulse; after gap 0A..0D with sof/eof.
- Truncation with MAX_WORDS=2: 3-word frame without eof -> 8 bytes, eof on byte 8, err_trunc pulse, third word discarded.
- Overflow and reset: dout_rdy=0, write 65 words -> din_full high after 64th, 65th dropped, ovf=1; rst_n=0 one cycle -> all outputs 0, FIFO empty, ovf=0.
